serial_frame_ctrl: RTL and testbench
====================================

Name: serial_frame_ctrl

Overview:
- Sequences the 8N1 serial receiver's byte stream into framed register-write commands for the slave's register bus.
- Sits between the receiver outputs (data byte, data-ready pulse, end-of-packet pulse) and the internal register file.
- Buffers one frame, validates its checksum, then issues the write burst over a valid/ready handshake.
- Discards malformed or truncated frames and counts them.

Parameters:
- SYNC_BYTE, 8'hAA, frame start marker.
- MAX_LEN, 16, maximum payload bytes per frame (1..255).
- ADDR_W, 8, register address width (>=8).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte, valid when rx_ready=1.
- rx_ready  in  1  one-cycle pulse, byte available.
- rx_eop  in  1  one-cycle pulse, line went idle (gap after burst).
- wr_addr  out  ADDR_W  register write address.
- wr_data  out  8  register write data.
- wr_valid  out  1  write request; held until accepted.
- wr_ready  in  1  register bus accepts when wr_valid&wr_ready.
- busy  out  1  high from SYNC detected until burst done or frame dropped.
- frame_ok  out  8  count of frames fully written, wraps 255->0.
- frame_err  out  8  count of dropped frames, wraps 255->0.

Behaviour:
- Async reset (rst_n=0): state=IDLE; wr_valid=0, wr_addr=0, wr_data=0, busy=0, frame_ok=0, frame_err=0; buffer contents don't-care. Reset mid-frame or mid-burst drops everything immediately, with no count update.
- Frame format: SYNC_BYTE, ADDR, LEN, LEN payload bytes, CSUM.
- CSUM = (ADDR+LEN+sum(payload)) mod 256, 8-bit wrapping add.
- States: IDLE, GET_ADDR, GET_LEN, GET_DATA, GET_CSUM, WRITE.
- IDLE:
  - rx_ready & rx_data==SYNC_BYTE -> GET_ADDR, busy=1.
  - Any other byte is ignored, with no error.
- GET_ADDR: on rx_ready, latch the base address, zero-extended to ADDR_W, and seed the sum -> GET_LEN.
- GET_LEN: on rx_ready, LEN==0 or LEN>MAX_LEN -> frame_err++, IDLE. Otherwise latch LEN, idx=0 -> GET_DATA.
- GET_DATA: on rx_ready, buf[idx]=rx_data, add to sum, idx++; when idx reaches LEN-1 on this byte -> GET_CSUM.
- GET_CSUM: on rx_ready:
  - byte==sum -> WRITE, idx=0.
  - Mismatch -> frame_err++, IDLE.
- rx_eop in GET_ADDR..GET_CSUM -> frame_err++, IDLE (truncated frame).
  - If rx_eop and rx_ready arrive in the same cycle, rx_eop wins and the byte is discarded.
- WRITE:
  - wr_valid=1, wr_addr=base+idx (mod 2^ADDR_W), wr_data=buf[idx].
  - On wr_valid&wr_ready: idx++. When the last byte is accepted, wr_valid=0 next cycle, frame_ok++, busy=0 -> IDLE.
  - wr_addr/wr_data are stable while wr_valid=1 and wr_ready=0.
  - Back-to-back acceptance with no bubble when wr_ready is held high: one write per cycle.
  - rx_ready/rx_eop during WRITE are ignored (byte lost). The host must wait for the gap.
- Latency: first wr_valid rises the cycle after the CSUM byte's rx_ready.
- busy falls in the same cycle as the counter update. Counters are registered outputs.

Test Plan:
- Good frame AA 10 03 01 02 03 19, wr_ready=1 -> writes (10,01),(11,02),(12,03) on consecutive cycles; frame_ok=1, frame_err=0, busy low after the last accept.
- Same frame with CSUM 18 -> no wr_valid; frame_err=1; the following good frame is still accepted (frame_ok=1).
- Backpressure: good frame with wr_ready toggling 0,0,1,0,1,1 -> each address/data pair held stable while stalled; exactly 3 accepts, in order.
- LEN=0 and LEN=MAX_LEN+1 frames -> frame_err increments by 2, no writes. Garbage bytes 55 00 before SYNC -> ignored, no error.
- Truncation and reset:
  - rx_eop after AA 20 02 05 -> frame_err++, IDLE.
  - rst_n pulsed low during WRITE of a 4-byte frame -> wr_valid=0 immediately, counters=0.
- Address wrap (ADDR_W=8): AA FE 03 .. with a valid CSUM -> addresses FE, FF, 00. frame_ok wraps from 255 to 0 on the 256th good frame.

Source files
------------

// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl
// Turns the 8N1 receiver byte stream into framed register-write bursts.
// Frame: SYNC_BYTE, ADDR, LEN, LEN payload bytes, CSUM where
// CSUM = ADDR + LEN + sum(payload) (8-bit wrapping). A frame is buffered
// and checksummed in full before any write is issued; malformed or
// truncated frames are dropped and counted in frame_err.
module serial_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'hAA,
    parameter int         MAX_LEN   = 16,
    parameter int         ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              rx_eop,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              busy,
    output logic [7:0]        frame_ok,
    output logic [7:0]        frame_err
);

    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_LEN,
        GET_DATA,
        GET_CSUM,
        WRITE
    } stateType;

    stateType          state, stateNext;
    logic [ADDR_W-1:0] baseAddr, baseNext;
    logic [7:0]        lenReg, lenNext;
    logic [7:0]        idx, idxNext;
    logic [7:0]        sumReg, sumNext;
    logic              bufWe;
    logic              okInc;
    logic              errInc;
    logic [7:0]        bufMem [MAX_LEN];

    // State and frame-context registers; reset drops any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baseAddr  <= '0;
            lenReg    <= '0;
            idx       <= '0;
            sumReg    <= '0;
            frame_ok  <= '0;
            frame_err <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            state    <= stateNext;
            baseAddr <= baseNext;
            lenReg   <= lenNext;
            idx      <= idxNext;
            sumReg   <= sumNext;
            if (okInc) begin
                frame_ok <= frame_ok + 8'd1;
            end
            if (errInc) begin
                frame_err <= frame_err + 8'd1;
            end
        end
    end

    // Payload buffer; contents are only read after being written in the same frame.
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset on purpose; its contents are don't-care
        // until written, and leaving it unreset lets it map onto plain RAM.
        if (bufWe) begin
            bufMem[idx[IDX_W-1:0]] <= rx_data;
        end
    end

    // Next-state and frame-context update; rx_eop beats rx_ready while receiving.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        stateNext = state;
        baseNext  = baseAddr;
        lenNext   = lenReg;
        idxNext   = idx;
        sumNext   = sumReg;
        bufWe     = 1'b0;
        okInc     = 1'b0;
        errInc    = 1'b0;

        case (state)
            IDLE: begin
                if (rx_ready && rx_data == SYNC_BYTE) begin
                    stateNext = GET_ADDR;
                end
            end

            GET_ADDR: begin
                if (rx_eop) begin
                    errInc    = 1'b1;
                    stateNext = IDLE;
                end else if (rx_ready) begin
                    baseNext  = ADDR_W'(rx_data);
                    sumNext   = rx_data;
                    stateNext = GET_LEN;
                end
            end

            GET_LEN: begin
                if (rx_eop) begin
                    errInc    = 1'b1;
                    stateNext = IDLE;
                end else if (rx_ready) begin
                    if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                        errInc    = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        lenNext   = rx_data;
                        idxNext   = 8'd0;
                        sumNext   = sumReg + rx_data;
                        stateNext = GET_DATA;
                    end
                end
            end

            GET_DATA: begin
                if (rx_eop) begin
                    errInc    = 1'b1;
                    stateNext = IDLE;
                end else if (rx_ready) begin
                    bufWe   = 1'b1;
                    sumNext = sumReg + rx_data;
                    idxNext = idx + 8'd1;
                    if (idx == lenReg - 8'd1) begin
                        stateNext = GET_CSUM;
                    end
                end
            end

            GET_CSUM: begin
                if (rx_eop) begin
                    errInc    = 1'b1;
                    stateNext = IDLE;
                end else if (rx_ready) begin
                    if (rx_data == sumReg) begin
                        idxNext   = 8'd0;
                        stateNext = WRITE;
                    end else begin
                        errInc    = 1'b1;
                        stateNext = IDLE;
                    end
                end
            end

            WRITE: begin
                // Receiver activity is ignored here; the host waits for the gap.
                if (wr_ready) begin
                    if (idx == lenReg - 8'd1) begin
                        okInc     = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        idxNext = idx + 8'd1;
                    end
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Write-port outputs decode straight from the state so the request is
    // held stable under backpressure and clears as soon as reset asserts.
    always_comb begin
        wr_valid = (state == WRITE);
        busy     = (state != IDLE);
        wr_addr  = '0;
        wr_data  = '0;
        if (state == WRITE) begin
            wr_addr = baseAddr + ADDR_W'(idx);
            wr_data = bufMem[idx[IDX_W-1:0]];
        end
    end

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Directed testbench for serial_frame_ctrl: frames are fed byte by byte and
// every observable output is compared against hand-computed values.
module tb_serial_frame_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_eop;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       busy;
    logic [7:0] frame_ok;
    logic [7:0] frame_err;

    int total = 0;
    int bad   = 0;
    logic [7:0] txQ [$];

    serial_frame_ctrl #(
        .SYNC_BYTE(8'hAA),
        .MAX_LEN  (16),
        .ADDR_W   (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .rx_eop   (rx_eop),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .busy     (busy),
        .frame_ok (frame_ok),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle 1 ns past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic sendQ();
        while (txQ.size() > 0) begin
            sendByte(txQ.pop_front());
        end
    endtask

    // Check the pending write request, then advance one cycle.
    task automatic checkWrite(input string tag, input logic [7:0] a, input logic [7:0] d);
        check({tag, ".valid"}, wr_valid, 1'b1);
        check({tag, ".addr"}, wr_addr, a);
        check({tag, ".data"}, wr_data, d);
        step();
    endtask

    task automatic checkIdle(input string tag, input logic [7:0] ok, input logic [7:0] err);
        check({tag, ".valid"}, wr_valid, 1'b0);
        check({tag, ".busy"}, busy, 1'b0);
        check({tag, ".ok"}, frame_ok, ok);
        check({tag, ".err"}, frame_err, err);
    endtask

    initial begin
        logic [7:0] stallPat [6];
        logic [7:0] expA     [6];
        logic [7:0] expD     [6];

        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        rx_eop   = 1'b0;
        wr_ready = 1'b0;
        repeat (3) step();
        check("reset.addr", wr_addr, 8'h00);
        check("reset.data", wr_data, 8'h00);
        checkIdle("reset", 8'd0, 8'd0);
        rst_n = 1'b1;
        step();

        // Good frame, no backpressure: three writes on consecutive cycles.
        wr_ready = 1'b1;
        sendByte(8'hAA);
        check("good1.busy_after_sync", busy, 1'b1);
        txQ = '{8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19};
        sendQ();
        check("good1.busy_in_write", busy, 1'b1);
        checkWrite("good1.w0", 8'h10, 8'h01);
        checkWrite("good1.w1", 8'h11, 8'h02);
        checkWrite("good1.w2", 8'h12, 8'h03);
        checkIdle("good1.done", 8'd1, 8'd0);

        // Bad checksum: dropped, no write; next good frame still accepted.
        txQ = '{8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h18};
        sendQ();
        checkIdle("badsum", 8'd1, 8'd1);
        step();
        check("badsum.no_write", wr_valid, 1'b0);
        txQ = '{8'hAA, 8'h40, 8'h01, 8'h7F, 8'hC0};
        sendQ();
        checkWrite("after_bad.w0", 8'h40, 8'h7F);
        checkIdle("after_bad.done", 8'd2, 8'd1);

        // Backpressure: pairs held while stalled, three accepts in order.
        stallPat = '{8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1};
        expA     = '{8'h30, 8'h30, 8'h30, 8'h31, 8'h31, 8'h32};
        expD     = '{8'h0A, 8'h0A, 8'h0A, 8'h0B, 8'h0B, 8'h0C};
        wr_ready = 1'b0;
        txQ = '{8'hAA, 8'h30, 8'h03, 8'h0A, 8'h0B, 8'h0C, 8'h54};
        sendQ();
        for (int i = 0; i < 6; i++) begin
            wr_ready = stallPat[i][0];
            checkWrite($sformatf("bp.c%0d", i), expA[i], expD[i]);
        end
        wr_ready = 1'b1;
        checkIdle("bp.done", 8'd3, 8'd1);

        // Garbage before SYNC is ignored; LEN=0 and LEN=MAX_LEN+1 are dropped.
        sendByte(8'h55);
        sendByte(8'h00);
        checkIdle("garbage", 8'd3, 8'd1);
        txQ = '{8'hAA, 8'h10, 8'h00};
        sendQ();
        checkIdle("len0", 8'd3, 8'd2);
        txQ = '{8'hAA, 8'h10, 8'h11};
        sendQ();
        checkIdle("len17", 8'd3, 8'd3);

        // LEN=MAX_LEN is the largest accepted frame: payload 01..10.
        txQ = '{8'hAA, 8'h00, 8'h10};
        for (int i = 1; i <= 16; i++) txQ.push_back(8'(i));
        txQ.push_back(8'h98);
        sendQ();
        for (int i = 0; i < 16; i++) begin
            checkWrite($sformatf("len16.w%0d", i), 8'(i), 8'(i + 1));
        end
        checkIdle("len16.done", 8'd4, 8'd3);

        // Truncated frame: rx_eop mid-payload.
        txQ = '{8'hAA, 8'h20, 8'h02, 8'h05};
        sendQ();
        check("trunc.busy_before", busy, 1'b1);
        rx_eop = 1'b1;
        step();
        rx_eop = 1'b0;
        checkIdle("trunc", 8'd4, 8'd4);

        // rx_eop and rx_ready together: eop wins, byte discarded.
        txQ = '{8'hAA, 8'h20, 8'h01};
        sendQ();
        rx_eop   = 1'b1;
        rx_data  = 8'h05;
        rx_ready = 1'b1;
        step();
        rx_eop   = 1'b0;
        rx_ready = 1'b0;
        checkIdle("eop_and_ready", 8'd4, 8'd5);

        // Reset asserted during WRITE of a 4-byte frame.
        wr_ready = 1'b0;
        txQ = '{8'hAA, 8'h50, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h5E};
        sendQ();
        check("rst_mid.valid_before", wr_valid, 1'b1);
        check("rst_mid.addr_before", wr_addr, 8'h50);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid.addr", wr_addr, 8'h00);
        checkIdle("rst_mid", 8'd0, 8'd0);
        step();
        #2;
        rst_n = 1'b1;
        step();
        checkIdle("rst_mid.after", 8'd0, 8'd0);

        // Address wrap across the 8-bit boundary.
        wr_ready = 1'b1;
        txQ = '{8'hAA, 8'hFE, 8'h03, 8'h11, 8'h22, 8'h33, 8'h67};
        sendQ();
        checkWrite("wrap.w0", 8'hFE, 8'h11);
        checkWrite("wrap.w1", 8'hFF, 8'h22);
        checkWrite("wrap.w2", 8'h00, 8'h33);
        checkIdle("wrap.done", 8'd1, 8'd0);

        // frame_ok wraps 255 -> 0 on the 256th good frame.
        for (int i = 0; i < 254; i++) begin
            txQ = '{8'hAA, 8'h00, 8'h01, 8'h05, 8'h06};
            sendQ();
            step();
        end
        checkIdle("okwrap.255", 8'd255, 8'd0);
        txQ = '{8'hAA, 8'h00, 8'h01, 8'h05, 8'h06};
        sendQ();
        checkWrite("okwrap.last", 8'h00, 8'h05);
        checkIdle("okwrap.0", 8'd0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
